// File: rtl/pc_next_seq.sv
// pc_next_seq: next-PC sequencer feeding the D input of a reset-less PC register.
// Owns the reset vector and boot cycle, holds under stall, buffers a redirect
// arriving during a stall and diverts misaligned jump/branch targets to the trap
// handler.
//
// Optional build macro: PC_REDIRECT_CNT_EN adds the REDIRECT_CNT output, a
// saturating count of cycles whose PC_SRC is branch/jump/trap/mret/pending.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BOOT  | first cycle after reset, drive RESET_VECTOR, ignore inputs
//   ST_RUN   | normal sequencing, no stall seen on the previous cycle
//   ST_HOLD  | previous cycle was stalled; a redirect may be buffered
module pc_next_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] STEP         = 32'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_Q,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        JMP,
    input  logic [31:0] JMP_TARGET,
    input  logic        TRAP_REQ,
    input  logic        MRET,
    output logic [31:0] PC_D,
    output logic [2:0]  PC_SRC,
    output logic [31:0] EPC,
    output logic        MISALIGN,
    output logic        PEND
`ifdef PC_REDIRECT_CNT_EN
   ,output logic [15:0] REDIRECT_CNT
`endif
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [2:0] SRC_SEQ  = 3'd0;
    localparam logic [2:0] SRC_BR   = 3'd1;
    localparam logic [2:0] SRC_JMP  = 3'd2;
    localparam logic [2:0] SRC_TRAP = 3'd3;
    localparam logic [2:0] SRC_MRET = 3'd4;
    localparam logic [2:0] SRC_PEND = 3'd5;
    localparam logic [2:0] SRC_HOLD = 3'd6;
    localparam logic [2:0] SRC_BOOT = 3'd7;

    logic [1:0]  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        misalign_q, misalign_d;
    // EPC may be written only once per stall; this remembers that it was.
    logic        epc_taken_q, epc_taken_d;

    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [2:0]  rd_src;
    logic        rd_mis;
    logic        jmp_mis;
    logic        br_mis;

    assign jmp_mis = |JMP_TARGET[1:0];
    assign br_mis  = |BR_TARGET[1:0];

    // Non-trap redirect choice (MRET > JMP > BR); misaligned targets become a trap.
    always_comb begin
        rd_valid = 1'b0;
        rd_addr  = '0;
        rd_src   = SRC_SEQ;
        rd_mis   = 1'b0;
        if (MRET) begin
            rd_valid = 1'b1;
            rd_addr  = epc_q;
            rd_src   = SRC_MRET;
        end else if (JMP) begin
            rd_valid = 1'b1;
            if (jmp_mis) begin
                rd_addr = TRAP_VECTOR;
                rd_src  = SRC_TRAP;
                rd_mis  = 1'b1;
            end else begin
                rd_addr = JMP_TARGET;
                rd_src  = SRC_JMP;
            end
        end else if (BR_TAKEN) begin
            rd_valid = 1'b1;
            if (br_mis) begin
                rd_addr = TRAP_VECTOR;
                rd_src  = SRC_TRAP;
                rd_mis  = 1'b1;
            end else begin
                rd_addr = BR_TARGET;
                rd_src  = SRC_BR;
            end
        end
    end

    // Next-PC selection, pending-redirect buffer and EPC/MISALIGN updates.
    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        misalign_d   = 1'b0;
        epc_taken_d  = epc_taken_q;
        PC_D         = PC_Q + STEP;
        PC_SRC       = SRC_SEQ;

        if (state_q == ST_BOOT) begin
            // Reset holds state_q at ST_BOOT, so this also covers RST=1.
            PC_D        = RESET_VECTOR;
            PC_SRC      = SRC_BOOT;
            state_d     = ST_RUN;
            epc_taken_d = 1'b0;
        end else if (STALL) begin
            state_d = ST_HOLD;
            PC_D    = PC_Q;
            PC_SRC  = SRC_HOLD;
            if (TRAP_REQ) begin
                // A trap always wins the buffer, even over an earlier redirect.
                pend_valid_d = 1'b1;
                pend_addr_d  = TRAP_VECTOR;
                if (!epc_taken_q) begin
                    epc_d       = PC_Q;
                    epc_taken_d = 1'b1;
                end
            end else if (!pend_valid_q && rd_valid) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = rd_addr;
                if (rd_mis) begin
                    misalign_d = 1'b1;
                    if (!epc_taken_q) begin
                        epc_d       = PC_Q;
                        epc_taken_d = 1'b1;
                    end
                end
            end
        end else if (pend_valid_q) begin
            // Release cycle: only a fresh trap can override the buffered target.
            state_d      = ST_RUN;
            pend_valid_d = 1'b0;
            epc_taken_d  = 1'b0;
            if (TRAP_REQ) begin
                PC_D   = TRAP_VECTOR;
                PC_SRC = SRC_TRAP;
                epc_d  = PC_Q;
            end else begin
                PC_D   = pend_addr_q;
                PC_SRC = SRC_PEND;
            end
        end else begin
            state_d     = ST_RUN;
            epc_taken_d = 1'b0;
            if (TRAP_REQ) begin
                PC_D   = TRAP_VECTOR;
                PC_SRC = SRC_TRAP;
                epc_d  = PC_Q;
            end else if (rd_valid) begin
                PC_D   = rd_addr;
                PC_SRC = rd_src;
                if (rd_mis) begin
                    epc_d      = PC_Q;
                    misalign_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset discards any buffered redirect and restarts at boot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_BOOT;
            epc_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            misalign_q   <= 1'b0;
            epc_taken_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            misalign_q   <= misalign_d;
            epc_taken_q  <= epc_taken_d;
        end
    end

    assign EPC      = epc_q;
    assign MISALIGN = misalign_q;
    assign PEND     = pend_valid_q;

`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt_q, redirect_cnt_d;
    logic        redirect_cyc;

    assign redirect_cyc = (PC_SRC >= SRC_BR) && (PC_SRC <= SRC_PEND);

    // Saturating count of redirect cycles.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redirect_cyc && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            redirect_cnt_q <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign REDIRECT_CNT = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_seq.sv
// Self-checking bench for pc_next_seq: table vectors, directed multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_pc_next_seq;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        CLK;
    logic        RST;
    logic [31:0] PC_Q;
    logic        STALL;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        JMP;
    logic [31:0] JMP_TARGET;
    logic        TRAP_REQ;
    logic        MRET;
    logic [31:0] PC_D;
    logic [2:0]  PC_SRC;
    logic [31:0] EPC;
    logic        MISALIGN;
    logic        PEND;
`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] REDIRECT_CNT;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_next_seq dut (
        .CLK(CLK), .RST(RST), .PC_Q(PC_Q), .STALL(STALL),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .JMP(JMP), .JMP_TARGET(JMP_TARGET),
        .TRAP_REQ(TRAP_REQ), .MRET(MRET),
        .PC_D(PC_D), .PC_SRC(PC_SRC), .EPC(EPC),
        .MISALIGN(MISALIGN), .PEND(PEND)
`ifdef PC_REDIRECT_CNT_EN
       ,.REDIRECT_CNT(REDIRECT_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model state: current and next.
    logic        m_boot, m_pv, m_mis, m_et;
    logic [31:0] m_pa, m_epc;
    int          m_cnt;
    logic        n_boot, n_pv, n_mis, n_et;
    logic [31:0] n_pa, n_epc;
    int          n_cnt;
    logic [31:0] exp_pc;
    logic [2:0]  exp_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_pv = 1'b0; m_pa = '0; m_epc = '0;
        m_mis = 1'b0; m_et = 1'b0; m_cnt = 0;
    endtask

    task automatic set_rst(input logic v);
        RST = v;
        if (v) model_reset();
    endtask

    task automatic idle();
        STALL = 0; BR_TAKEN = 0; JMP = 0; TRAP_REQ = 0; MRET = 0;
        BR_TARGET = '0; JMP_TARGET = '0;
    endtask

    // Expected outputs for the current inputs and the model state after the edge.
    task automatic model_eval();
        logic [31:0] t;
        n_boot = m_boot; n_pv = m_pv; n_pa = m_pa; n_epc = m_epc;
        n_mis = 1'b0; n_et = m_et; n_cnt = m_cnt;
        exp_pc = PC_Q + 32'd4;
        exp_src = 3'd0;
        t = JMP ? JMP_TARGET : BR_TARGET;
        if (RST) begin
            exp_pc = RV; exp_src = 3'd7;
            n_boot = 1; n_pv = 0; n_pa = '0; n_epc = '0; n_et = 0; n_cnt = 0;
        end else if (m_boot) begin
            exp_pc = RV; exp_src = 3'd7; n_boot = 0;
        end else if (STALL) begin
            exp_pc = PC_Q; exp_src = 3'd6;
            if (TRAP_REQ) begin
                n_pv = 1; n_pa = TV;
                if (!m_et) begin n_epc = PC_Q; n_et = 1; end
            end else if (!m_pv) begin
                if (MRET) begin
                    n_pv = 1; n_pa = m_epc;
                end else if (JMP || BR_TAKEN) begin
                    n_pv = 1;
                    if (t % 4 != 0) begin
                        n_pa = TV; n_mis = 1; n_epc = PC_Q; n_et = 1;
                    end else begin
                        n_pa = t;
                    end
                end
            end
        end else if (m_pv) begin
            n_pv = 0; n_et = 0;
            if (TRAP_REQ) begin
                exp_pc = TV; exp_src = 3'd3; n_epc = PC_Q;
            end else begin
                exp_pc = m_pa; exp_src = 3'd5;
            end
        end else begin
            n_et = 0;
            if (TRAP_REQ) begin
                exp_pc = TV; exp_src = 3'd3; n_epc = PC_Q;
            end else if (MRET) begin
                exp_pc = m_epc; exp_src = 3'd4;
            end else if (JMP || BR_TAKEN) begin
                if (t % 4 != 0) begin
                    exp_pc = TV; exp_src = 3'd3; n_epc = PC_Q; n_mis = 1;
                end else begin
                    exp_pc = t; exp_src = JMP ? 3'd2 : 3'd1;
                end
            end
        end
        if (!RST && exp_src >= 3'd1 && exp_src <= 3'd5 && m_cnt < 65535) n_cnt = m_cnt + 1;
    endtask

    // One clock: compare against the model, clock, feed PC_D back as PC_Q.
    task automatic tick();
        logic [31:0] pd;
        #1;
        model_eval();
        chk("pc_d", PC_D, exp_pc);
        chk("pc_src", 32'(PC_SRC), 32'(exp_src));
        chk("epc", EPC, m_epc);
        chk("misalign", 32'(MISALIGN), 32'(m_mis));
        chk("pend", 32'(PEND), 32'(m_pv));
`ifdef PC_REDIRECT_CNT_EN
        chk("redirect_cnt", 32'(REDIRECT_CNT), 32'(m_cnt));
`endif
        pd = PC_D;
        @(posedge CLK);
        m_boot = n_boot; m_pv = n_pv; m_pa = n_pa; m_epc = n_epc;
        m_mis = n_mis; m_et = n_et; m_cnt = n_cnt;
        #1;
        PC_Q = pd;
    endtask

    typedef struct {
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        tr;
        logic        mr;
        logic [31:0] pcq;
        logic [31:0] exp_pc;
        logic [2:0]  exp_src;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Rows run back to back from RUN; the MRET row relies on the trap row before it.
        vecs[0] = '{0, 32'h0,         0, 32'h0,   0, 0, 32'h0000_1000, 32'h0000_1004, 3'd0};
        vecs[1] = '{1, 32'h80,        1, 32'h200, 0, 0, 32'h0000_0040, 32'h0000_0200, 3'd2};
        vecs[2] = '{1, 32'h80,        0, 32'h0,   0, 0, 32'h0000_0040, 32'h0000_0080, 3'd1};
        vecs[3] = '{0, 32'h0,         0, 32'h0,   0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 3'd0};
        vecs[4] = '{0, 32'h0,         1, 32'h200, 1, 1, 32'h0000_0500, TV,            3'd3};
        vecs[5] = '{0, 32'h0,         0, 32'h0,   0, 1, 32'h0000_0700, 32'h0000_0500, 3'd4};
        vecs[6] = '{0, 32'h0,         1, 32'h203, 0, 0, 32'h0000_0060, TV,            3'd3};
        vecs[7] = '{1, 32'h81,        1, 32'h204, 0, 0, 32'h0000_0008, 32'h0000_0204, 3'd2};

        idle();
        PC_Q = '0;
        RST = 0;
        model_reset();
        #1;
        set_rst(1);

        // Reset then boot, then sequential fetch.
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_pc_d", PC_D, RV);
            chk("rst_src", 32'(PC_SRC), 32'd7);
            tick();
        end
        set_rst(0);
        #1;
        chk("boot_pc_d", PC_D, RV);
        chk("boot_src", 32'(PC_SRC), 32'd7);
        tick();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("seq_pc_d", PC_D, 32'(4 * i));
            tick();
        end

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            idle();
            BR_TAKEN = vecs[i].br; BR_TARGET = vecs[i].bt;
            JMP = vecs[i].j; JMP_TARGET = vecs[i].jt;
            TRAP_REQ = vecs[i].tr; MRET = vecs[i].mr;
            PC_Q = vecs[i].pcq;
            #1;
            chk($sformatf("vec%0d_pc_d", i), PC_D, vecs[i].exp_pc);
            chk($sformatf("vec%0d_src", i), 32'(PC_SRC), 32'(vecs[i].exp_src));
            tick();
        end

        // Stall with buffered jump; later branch ignored.
        idle();
        PC_Q = 32'h10;
        STALL = 1; JMP = 1; JMP_TARGET = 32'h300;
        #1;
        chk("stall1_pc_d", PC_D, 32'h10);
        chk("stall1_src", 32'(PC_SRC), 32'd6);
        tick();
        JMP = 0; BR_TAKEN = 1; BR_TARGET = 32'h500;
        #1;
        chk("stall2_pc_d", PC_D, 32'h10);
        chk("stall2_pend", 32'(PEND), 32'd1);
        tick();
        BR_TAKEN = 0;
        #1;
        chk("stall3_pc_d", PC_D, 32'h10);
        chk("stall3_pend", 32'(PEND), 32'd1);
        tick();
        STALL = 0;
        #1;
        chk("release_pc_d", PC_D, 32'h300);
        chk("release_src", 32'(PC_SRC), 32'd5);
        tick();
        #1;
        chk("after_release_pc_d", PC_D, 32'h304);
        chk("after_release_pend", 32'(PEND), 32'd0);
        tick();

        // Misaligned branch, then return.
        idle();
        PC_Q = 32'h24;
        BR_TAKEN = 1; BR_TARGET = 32'h62;
        #1;
        chk("mis_pc_d", PC_D, TV);
        chk("mis_src", 32'(PC_SRC), 32'd3);
        tick();
        BR_TAKEN = 0; MRET = 1;
        #1;
        chk("mis_pulse", 32'(MISALIGN), 32'd1);
        chk("mis_epc", EPC, 32'h24);
        chk("mret_pc_d", PC_D, 32'h24);
        tick();
        MRET = 0;
        #1;
        chk("mis_clear", 32'(MISALIGN), 32'd0);
        tick();

        // Reset during a stall with a buffered redirect.
        idle();
        STALL = 1; JMP = 1; JMP_TARGET = 32'h400;
        tick();
        JMP = 0;
        #1;
        chk("pre_rst_pend", 32'(PEND), 32'd1);
        set_rst(1);
        #1;
        chk("rst_pend", 32'(PEND), 32'd0);
        chk("rst_mid_pc_d", PC_D, RV);
        tick();
        set_rst(0);
        STALL = 0;
        #1;
        chk("reboot_pc_d", PC_D, RV);
        chk("reboot_src", 32'(PC_SRC), 32'd7);
`ifdef PC_REDIRECT_CNT_EN
        chk("reboot_cnt", 32'(REDIRECT_CNT), 32'd0);
`endif
        tick();
        #1;
        chk("reboot_seq", PC_D, RV + 32'd4);
        tick();

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            if (RST) set_rst(0);
            else if ($urandom_range(0, 99) == 0) set_rst(1);
            STALL    = ($urandom_range(0, 9) < 3);
            TRAP_REQ = ($urandom_range(0, 15) == 0);
            MRET     = ($urandom_range(0, 11) == 0);
            JMP      = ($urandom_range(0, 7) == 0);
            BR_TAKEN = ($urandom_range(0, 5) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            JMP_TARGET = t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            BR_TARGET = t;
            if ($urandom_range(0, 19) == 0) begin
                t = $urandom;
                t[1:0] = 2'b00;
                PC_Q = t;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_next_seq.md
Name: pc_next_seq

Overview:
- Next-PC sequencer directly upstream of the PC register: drives its D input every cycle and reads back its Q output.
- Selects the next PC from the sequential, branch, jump, trap and return sources, in that priority inversion noted under Behaviour.
- Owns the reset vector and handles the boot cycle, because the PC register has no reset.
- Holds the PC under stall, buffers a redirect that arrives during a stall, and traps on a misaligned target.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded out of reset.
- TRAP_VECTOR, 32'h0000_0100, handler address for traps and misaligned targets.
- STEP, 4, sequential increment in bytes.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- PC_Q  in  32  current PC, from the PC register output.
- STALL  in  1  hold the PC this cycle.
- BR_TAKEN  in  1  conditional branch taken.
- BR_TARGET  in  32  branch target.
- JMP  in  1  unconditional jump.
- JMP_TARGET  in  32  jump target.
- TRAP_REQ  in  1  synchronous exception or ecall.
- MRET  in  1  return from trap.
- PC_D  out  32  next PC, to the PC register D input; combinational from inputs and state.
- PC_SRC  out  3  selected source: 0 seq, 1 branch, 2 jump, 3 trap, 4 mret, 5 pending, 6 hold, 7 boot.
- EPC  out  32  registered exception PC.
- MISALIGN  out  1  one-cycle pulse on a misaligned redirect.
- PEND  out  1  a buffered redirect is waiting.

Behaviour:
- Reset (asynchronous, active-high): state=BOOT, EPC=0, pend_valid=0, pend_addr=0, MISALIGN=0.
  - While RST=1, PC_D=RESET_VECTOR and PC_SRC=7.
- BOOT: lasts one cycle after RST deasserts. PC_D=RESET_VECTOR, PC_SRC=7, all other inputs ignored. Next state is RUN.
- RUN with STALL=0 and pend_valid=0: source priority is TRAP_REQ > MRET > JMP > BR_TAKEN > sequential.
  - Sequential: PC_D = PC_Q+STEP, modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.
  - Trap: PC_D=TRAP_VECTOR; EPC <= PC_Q at the next edge.
  - MRET: PC_D=EPC.
  - Jump/branch with target[1:0]!=0: treated as a trap. PC_D=TRAP_VECTOR, EPC <= PC_Q, MISALIGN=1 for the following cycle. MISALIGN is registered and clears after one cycle.
  - Simultaneous TRAP_REQ and MRET: TRAP_REQ wins and MRET is dropped.
- STALL=1 (state HOLD): PC_D=PC_Q, PC_SRC=6.
  - A redirect during stall (TRAP/MRET/JMP/BR) is latched into pend_addr/pend_valid using the same priority and misalignment rules. Misalignment stores TRAP_VECTOR, captures EPC and pulses MISALIGN.
  - With pend_valid=1, a later JMP or BR during the same stall is ignored.
  - A later TRAP_REQ overwrites the pending entry with TRAP_VECTOR and captures EPC.
  - EPC is captured at most once per stall, by the first trap.
- Stall release (STALL=0 with pend_valid=1): PC_D=pend_addr, PC_SRC=5, pend_valid cleared at the edge.
  - Redirect inputs arriving in the release cycle are ignored, except TRAP_REQ, which takes priority and discards the pending entry.
- Returning to RUN: state goes back to RUN when STALL=0 and pend_valid=0.
- PEND equals pend_valid.
- Asserting RST mid-stall discards the pending entry and restarts at BOOT.
- Latency:
  - Input to PC_D is combinational, 0 cycles.
  - The PC register reflects PC_D one edge later.
  - EPC, MISALIGN and PEND are registered.

Optional Feature:
- Macro PC_REDIRECT_CNT_EN.
- Defined: adds output REDIRECT_CNT (16 bits), a saturating count of cycles with PC_SRC in {1,2,3,4,5}. It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- RST high 3 cycles, then release, PC_Q fed back from a model PC register -> PC_D=0 during reset and BOOT. Next cycles give 4, 8, 12.
- PC_Q=0x40 with BR_TAKEN=1, BR_TARGET=0x80, JMP=1, JMP_TARGET=0x200 -> PC_D=0x200, PC_SRC=2.
- STALL=1 for 3 cycles at PC 0x10, JMP to 0x300 in the 1st stall cycle and BR to 0x500 in the 2nd -> PC_D=0x10 throughout, PEND=1. On release PC_D=0x300, then 0x304.
- PC_Q=0x24, BR_TAKEN=1, BR_TARGET=0x62 -> PC_D=0x100, next cycle MISALIGN=1 and EPC=0x24. Then MRET=1 -> PC_D=0x24.
- PC_Q=0xFFFF_FFFC, no redirect -> PC_D=0x0000_0000.
- RST asserted mid-stall with PEND=1 -> PEND=0 immediately. After release, PC_D=RESET_VECTOR for one cycle. With PC_REDIRECT_CNT_EN defined, REDIRECT_CNT=0.
